// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage.
package wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 1 << AW;

    // Source that loads the output register in a given cycle
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    // One result headed for the register file
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_res_t;

    // x0 is hardwired to zero: results aimed at it never write
    function automatic logic writes_reg(input logic [AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the result inputs, issue/query ports and register file write port
// seen by the writeback stage.
interface wb_stage_if;
    import wb_pkg::*;

    // ALU result (no backpressure)
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    // LSU/MUL result with ready handshake
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;

    // Long-latency issue marker
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;

    // Scoreboard queries
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            chk_busy1;
    logic            chk_busy2;

    // Register file write port
    logic            rg_wrt_en;
    logic [AW-1:0]   rg_wrt_add;
    logic [XLEN-1:0] rg_wrt_data;

    // Upstream pipeline / environment side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_valid, iss_rd,
        output chk_rs1, chk_rs2,
        input  chk_busy1, chk_busy2,
        input  rg_wrt_en, rg_wrt_add, rg_wrt_data
    );

    // Writeback stage side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_valid, iss_rd,
        input  chk_rs1, chk_rs2,
        output chk_busy1, chk_busy2,
        output rg_wrt_en, rg_wrt_add, rg_wrt_data
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations. A bit is set when a
// long-latency op issues and cleared when its result loads the output register.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear first so a same-cycle reissue to that rd wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && writes_reg(set_rd)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Queries read state only, so a result clears its bit in the same cycle it
    // appears on the write port and consumers forward from the write data.
    assign busy1 = writes_reg(rs1) & busy_q[rs1];
    assign busy2 = writes_reg(rs2) & busy_q[rs2];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage feeding the register file write port. Merges the single-cycle
// ALU result and the handshaked LSU/MUL result with fixed ALU priority; an LSU
// result that loses arbitration waits in a one-entry skid buffer.
module wb_stage
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    // Skid buffer for an accepted LSU result blocked by the ALU
    logic    skid_full_q;
    logic    skid_full_d;
    wb_res_t skid_q;
    wb_res_t skid_d;

    // Registered write port
    logic            en_q;
    logic            en_d;
    logic [AW-1:0]   add_q;
    logic [AW-1:0]   add_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;

    // Arbitration result for this cycle
    wb_src_e src;
    wb_res_t sel;
    logic    lsu_acc;

    assign bus.lsu_ready = !skid_full_q;
    assign lsu_acc       = bus.lsu_valid & !skid_full_q;

    // Fixed priority: ALU, then the held skid entry, then a fresh LSU result
    always_comb begin
        src = WB_NONE;
        sel = '0;
        if (bus.alu_valid) begin
            src      = WB_ALU;
            sel.rd   = bus.alu_rd;
            sel.data = bus.alu_data;
        end else if (skid_full_q) begin
            src = WB_LSU;
            sel = skid_q;
        end else if (lsu_acc) begin
            src      = WB_LSU;
            sel.rd   = bus.lsu_rd;
            sel.data = bus.lsu_data;
        end
    end

    // Skid next state: drain on the first ALU bubble, capture an LSU loser.
    // While full, ready is low, so capture and drain never overlap.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        if (skid_full_q) begin
            if (!bus.alu_valid) begin
                skid_full_d = 1'b0;
            end
        end else if (lsu_acc && bus.alu_valid) begin
            skid_full_d = 1'b1;
            skid_d.rd   = bus.lsu_rd;
            skid_d.data = bus.lsu_data;
        end
    end

    // Output register next state: address/data only move on a real write
    always_comb begin
        en_d   = (src != WB_NONE) && writes_reg(sel.rd);
        add_d  = add_q;
        data_d = data_q;
        if (en_d) begin
            add_d  = sel.rd;
            data_d = sel.data;
        end
    end

    // Skid and output registers; reset drops any held LSU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            en_q        <= 1'b0;
            add_q       <= '0;
            data_q      <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            en_q        <= en_d;
            add_q       <= add_d;
            data_q      <= data_d;
        end
    end

    assign bus.rg_wrt_en   = en_q;
    assign bus.rg_wrt_add  = add_q;
    assign bus.rg_wrt_data = data_q;

    // Only LSU-sourced results retire long-latency destinations
    wb_scoreboard u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (bus.iss_valid),
        .set_rd (bus.iss_rd),
        .clr_en (src == WB_LSU),
        .clr_rd (sel.rd),
        .rs1    (bus.chk_rs1),
        .rs2    (bus.chk_rs2),
        .busy1  (bus.chk_busy1),
        .busy2  (bus.chk_busy2)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_wb_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_stage_if bus ();

    wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t        lsu_q[$];   // accepted LSU results not yet retired
    bit          m_en;
    logic [4:0]  m_add;
    logic [31:0] m_data;
    bit          m_busy[32];
    bit          last_taken;

    function automatic void model_reset();
        lsu_q.delete();
        m_en = 0;
        m_add = '0;
        m_data = '0;
        last_taken = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endfunction

    function automatic bit model_busy(input logic [4:0] rs);
        return (rs != 0) && m_busy[rs];
    endfunction

    // Effect of the coming rising edge, from the inputs currently applied
    function automatic void model_edge();
        bit   ret = 0;
        bit   from_lsu = 0;
        res_t r = '{rd: 5'd0, data: 32'd0};
        last_taken = bus.lsu_valid && (lsu_q.size() == 0);
        if (last_taken) lsu_q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
        if (bus.alu_valid) begin
            ret = 1;
            r = '{rd: bus.alu_rd, data: bus.alu_data};
        end else if (lsu_q.size() != 0) begin
            ret = 1;
            from_lsu = 1;
            r = lsu_q.pop_front();
        end
        m_en = ret && (r.rd != 0);
        if (m_en) begin
            m_add = r.rd;
            m_data = r.data;
        end
        if (from_lsu) m_busy[r.rd] = 0;
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1;
    endfunction

    // One clock cycle: entered just after a falling edge with inputs applied
    task automatic step();
        #1;
        chk("chk_busy1", bus.chk_busy1, model_busy(bus.chk_rs1));
        chk("chk_busy2", bus.chk_busy2, model_busy(bus.chk_rs2));
        model_edge();
        @(posedge clk);
        #1;
        chk("rg_wrt_en", bus.rg_wrt_en, m_en);
        chk("rg_wrt_add", bus.rg_wrt_add, m_add);
        chk("rg_wrt_data", bus.rg_wrt_data, m_data);
        chk("lsu_ready", bus.lsu_ready, lsu_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 0;
        bus.lsu_valid = 0;
        bus.iss_valid = 0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid = 1;
        bus.alu_rd = rd;
        bus.alu_data = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
        bus.lsu_valid = 1;
        bus.lsu_rd = rd;
        bus.lsu_data = data;
    endtask

    task automatic drive_iss(input logic [4:0] rd);
        bus.iss_valid = 1;
        bus.iss_rd = rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.chk_rs1 = 0;   bus.chk_rs2 = 0;
        model_reset();

        // Power-on reset values
        #12;
        chk("reset en", bus.rg_wrt_en, 0);
        chk("reset add", bus.rg_wrt_add, 0);
        chk("reset data", bus.rg_wrt_data, 0);
        chk("reset ready", bus.lsu_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // ALU only: one-cycle latency, one-cycle pulse
        drive_alu(5, 32'hDEADBEEF);
        step();
        chk("alu en", bus.rg_wrt_en, 1);
        chk("alu add", bus.rg_wrt_add, 5);
        chk("alu data", bus.rg_wrt_data, 32'hDEADBEEF);
        idle();
        step();
        chk("alu pulse", bus.rg_wrt_en, 0);
        chk("idle hold add", bus.rg_wrt_add, 5);

        // Collision: ALU x3 wins, LSU x4 waits one cycle
        drive_alu(3, 32'h3333_0003);
        drive_lsu(4, 32'h4444_0004);
        step();
        chk("coll alu add", bus.rg_wrt_add, 3);
        chk("coll ready low", bus.lsu_ready, 0);
        idle();
        step();
        chk("coll lsu en", bus.rg_wrt_en, 1);
        chk("coll lsu add", bus.rg_wrt_add, 4);
        chk("coll lsu data", bus.rg_wrt_data, 32'h4444_0004);
        chk("coll ready back", bus.lsu_ready, 1);
        step();

        // LSU blocked by two ALU cycles: skid holds while ALU keeps winning
        drive_alu(1, 32'h0000_0011);
        drive_lsu(2, 32'h0000_0022);
        step();
        bus.lsu_valid = 0;
        drive_alu(8, 32'h0000_0088);
        step();
        chk("block2 add", bus.rg_wrt_add, 8);
        chk("block2 ready", bus.lsu_ready, 0);
        idle();
        step();
        chk("block2 lsu add", bus.rg_wrt_add, 2);
        chk("block2 lsu data", bus.rg_wrt_data, 32'h0000_0022);

        // x0 results: handshake completes, no write, port holds
        drive_alu(0, 32'h1234_5678);
        step();
        chk("x0 alu en", bus.rg_wrt_en, 0);
        chk("x0 alu data", bus.rg_wrt_data, 32'h0000_0022);
        idle();
        drive_lsu(0, 32'h0000_0009);
        step();
        chk("x0 lsu en", bus.rg_wrt_en, 0);
        chk("x0 lsu ready", bus.lsu_ready, 1);
        idle();
        step();

        // Scoreboard: pending from issue until the LSU write cycle
        drive_iss(7);
        step();
        idle();
        bus.chk_rs1 = 7;
        bus.chk_rs2 = 0;
        #1;
        chk("sb busy x7", bus.chk_busy1, 1);
        chk("sb x0 query", bus.chk_busy2, 0);
        step();
        drive_lsu(7, 32'h0000_0077);
        step();
        chk("sb wr en", bus.rg_wrt_en, 1);
        chk("sb wr add", bus.rg_wrt_add, 7);
        chk("sb cleared", bus.chk_busy1, 0);
        idle();

        // Set/clear race on x7: set wins
        drive_iss(7);
        step();
        idle();
        drive_lsu(7, 32'h0000_0070);
        drive_iss(7);
        step();
        chk("race wr add", bus.rg_wrt_add, 7);
        chk("race busy", bus.chk_busy1, 1);
        idle();
        drive_lsu(7, 32'h0000_0071);
        step();
        chk("race later clear", bus.chk_busy1, 0);
        idle();

        // Reset mid-transfer with the skid full
        drive_alu(9, 32'h0000_0099);
        drive_lsu(10, 32'h0000_00AA);
        drive_iss(12);
        step();
        chk("pre-reset skid full", bus.lsu_ready, 0);
        idle();
        #2;
        rst_n = 0;
        #1;
        chk("midreset en", bus.rg_wrt_en, 0);
        chk("midreset add", bus.rg_wrt_add, 0);
        chk("midreset data", bus.rg_wrt_data, 0);
        chk("midreset ready", bus.lsu_ready, 1);
        for (int rs = 0; rs < 32; rs++) begin
            bus.chk_rs1 = rs[4:0];
            #1;
            chk("midreset busy", bus.chk_busy1, 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bus.chk_rs1 = 0;
        step();
        chk("post-reset no write", bus.rg_wrt_en, 0);
        chk("post-reset ready", bus.lsu_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] r;
            bus.alu_valid = ($urandom_range(0, 1) == 0);
            bus.alu_rd = 5'($urandom_range(0, 31));
            bus.alu_data = $urandom;
            // Offered LSU result that was not taken must stay stable
            if (!(bus.lsu_valid && !last_taken)) begin
                bus.lsu_valid = ($urandom_range(0, 4) < 2);
                bus.lsu_rd = 5'($urandom_range(0, 31));
                bus.lsu_data = $urandom;
            end
            r = 5'($urandom_range(0, 31));
            bus.iss_valid = ($urandom_range(0, 3) == 0) && !m_busy[r];
            bus.iss_rd = r;
            bus.chk_rs1 = 5'($urandom_range(0, 31));
            bus.chk_rs2 = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
